collision_matrix: RTL and testbench

COLLISION_MATRIX -- requirements
Module: collision_matrix

---
 rtl/collision_pkg.sv | 23 ++
 rtl/collision_matrix_if.sv | 17 +
 rtl/collision_evt_fifo.sv | 57 +++++
 rtl/collision_matrix.sv | 163 ++++++++++++++++
 tb/tb_collision_matrix.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/collision_pkg.sv
// Shared types and defaults for the collision matrix block.
// Holds the pair-event record that the event FIFO carries, the default
// object counts and FIFO depth, and the index-width helper used by the
// interface and the top level.
package collision_pkg;

    localparam int DEF_N_A       = 4;
    localparam int DEF_N_B       = 8;
    localparam int DEF_EVT_DEPTH = 4;

    // Indices are stored at the widest supported size (16 objects per group)
    // and narrowed at the outputs.
    typedef struct packed {
        logic [3:0] a_idx;
        logic [3:0] b_idx;
    } pair_evt_t;

    // Index width for a group of n objects; a single object still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/collision_matrix_if.sv
// Pair-event stream of the collision matrix: valid/ready handshake plus the
// A and B indices of the colliding pair. The producer (collision_matrix) uses
// the master modport, the event consumer uses the slave modport.
interface collision_matrix_if
    import collision_pkg::*;
#(
    parameter int N_A = DEF_N_A,
    parameter int N_B = DEF_N_B
);
    logic                  evtValid;
    logic [idx_w(N_A)-1:0] evtA;
    logic [idx_w(N_B)-1:0] evtB;
    logic                  evtReady;

    modport master (output evtValid, output evtA, output evtB, input evtReady);
    modport slave  (input evtValid, input evtA, input evtB, output evtReady);
endinterface

// File: rtl/collision_evt_fifo.sv
// First-word-fall-through FIFO for pair events.
// Pointers carry one extra wrap bit so full and empty are told apart by the
// MSB. A push while full is accepted only when a pop happens in the same
// cycle (the popped slot is the one being written).
module collision_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, full, do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);

    assign valid_o = ~empty;
    assign full_o  = full;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Next pointer values from accepted push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is data only and needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/collision_matrix.sv
// Collision matrix between two object groups (A, e.g. birds; B, e.g. shots).
// Tracks per-object and per-pair "hit this frame" flags, pulses on an
// object's first hit, counts distinct pairs per frame (saturating) and
// queues one pair event per cycle.
// Optional feature: define COLLISION_MATRIX_EVT_FIFO_EN to build the pair-event
// FIFO and overflow flag; without it the event stream and overflow read 0.
module collision_matrix
    import collision_pkg::*;
#(
    parameter int N_A       = DEF_N_A,
    parameter int N_B       = DEF_N_B,
    parameter int EVT_DEPTH = DEF_EVT_DEPTH,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic [N_A-1:0]   reqA,
    input  logic [N_B-1:0]   reqB,
    output logic [N_A-1:0]   hitPulseA,
    output logic [N_B-1:0]   hitPulseB,
    output logic [N_A-1:0]   hitFrameA,
    output logic [N_B-1:0]   hitFrameB,
    output logic [CNT_W-1:0] pairCount,
    output logic             overflow,
    collision_matrix_if.master evt
);
    localparam int A_W   = idx_w(N_A);
    localparam int B_W   = idx_w(N_B);
    localparam int NEW_W = $clog2(N_A * N_B + 1);

    logic                      collision;
    logic [N_A-1:0]            hitA, flagA_eff, flagA_d, flagA_q, pulseA_d, pulseA_q;
    logic [N_B-1:0]            hitB, flagB_eff, flagB_d, flagB_q, pulseB_d, pulseB_q;
    logic [N_A-1:0][N_B-1:0]   pair_eff, pair_new, pair_d, pair_q;
    logic [NEW_W-1:0]          cnt_new;
    logic [CNT_W-1:0]          cnt_d, cnt_q;

    // Saturating add of this cycle's new pairs onto the frame count.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [NEW_W-1:0] b);
        logic [CNT_W+NEW_W:0] s;
        s = {{(NEW_W+1){1'b0}}, a} + {{(CNT_W+1){1'b0}}, b};
        if (s > {{(NEW_W+1){1'b0}}, {CNT_W{1'b1}}}) return '1;
        return s[CNT_W-1:0];
    endfunction

    // Per-object hits, judged against flags already cleared by a frame start.
    always_comb begin
        collision = (|reqA) && (|reqB);
        flagA_eff = startOfFrame ? '0 : flagA_q;
        flagB_eff = startOfFrame ? '0 : flagB_q;
        hitA      = collision ? reqA : '0;
        hitB      = collision ? reqB : '0;
        pulseA_d  = hitA & ~flagA_eff;
        pulseB_d  = hitB & ~flagB_eff;
        flagA_d   = flagA_eff | hitA;
        flagB_d   = flagB_eff | hitB;
    end

    // Pair matrix: newly set pairs this cycle and their count.
    always_comb begin
        pair_eff = startOfFrame ? '0 : pair_q;
        pair_new = '0;
        cnt_new  = '0;
        for (int i = 0; i < N_A; i++) begin
            for (int j = 0; j < N_B; j++) begin
                pair_new[i][j] = reqA[i] & reqB[j] & ~pair_eff[i][j];
                cnt_new        = cnt_new + NEW_W'(pair_new[i][j]);
            end
        end
        pair_d = pair_eff | pair_new;
        cnt_d  = sat_add(startOfFrame ? '0 : cnt_q, cnt_new);
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flagA_q  <= '0;
            flagB_q  <= '0;
            pulseA_q <= '0;
            pulseB_q <= '0;
            pair_q   <= '0;
            cnt_q    <= '0;
        end else begin
            flagA_q  <= flagA_d;
            flagB_q  <= flagB_d;
            pulseA_q <= pulseA_d;
            pulseB_q <= pulseB_d;
            pair_q   <= pair_d;
            cnt_q    <= cnt_d;
        end
    end

    assign hitPulseA = pulseA_q;
    assign hitPulseB = pulseB_q;
    assign hitFrameA = flagA_q;
    assign hitFrameB = flagB_q;
    assign pairCount = cnt_q;

`ifdef COLLISION_MATRIX_EVT_FIFO_EN
    logic      evt_found;
    pair_evt_t evt_sel, fifo_dout;
    logic      fifo_valid, fifo_full, fifo_pop;
    logic      overflow_d, overflow_q;
    logic      unused_evt_bits;

    // Pick the single event to queue: lowest A index, then lowest B index.
    always_comb begin
        evt_found = 1'b0;
        evt_sel   = '0;
        for (int i = 0; i < N_A; i++) begin
            for (int j = 0; j < N_B; j++) begin
                if (pair_new[i][j] && !evt_found) begin
                    evt_found     = 1'b1;
                    evt_sel.a_idx = 4'(i);
                    evt_sel.b_idx = 4'(j);
                end
            end
        end
    end

    assign fifo_pop = fifo_valid & evt.evtReady;

    collision_evt_fifo #(
        .WIDTH ($bits(pair_evt_t)),
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .resetN  (resetN),
        .push_i  (evt_found),
        .data_i  (evt_sel),
        .pop_i   (fifo_pop),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .data_o  (fifo_dout)
    );

    // A dropped event (full, no simultaneous pop) latches overflow until reset.
    assign overflow_d = overflow_q | (evt_found & fifo_full & ~fifo_pop);

    // Sticky overflow register; frame start leaves it alone.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) overflow_q <= 1'b0;
        else         overflow_q <= overflow_d;
    end

    assign evt.evtValid    = fifo_valid;
    assign evt.evtA        = fifo_dout.a_idx[A_W-1:0];
    assign evt.evtB        = fifo_dout.b_idx[B_W-1:0];
    assign overflow        = overflow_q;
    assign unused_evt_bits = ^{fifo_dout.a_idx, fifo_dout.b_idx};
`else
    logic unused_evt_ready;

    assign evt.evtValid     = 1'b0;
    assign evt.evtA         = '0;
    assign evt.evtB         = '0;
    assign overflow         = 1'b0;
    assign unused_evt_ready = evt.evtReady;
`endif

endmodule

// File: tb/tb_collision_matrix.sv
// Bench for collision_matrix: directed scenarios plus a randomized stretch,
// checked against a frame-level reference model (flag arrays, pair set,
// event queue). A second 16x16 instance covers pair-count saturation.
module tb_collision_matrix;
    import collision_pkg::*;

    localparam int NA    = 4;
    localparam int NB    = 8;
    localparam int DEPTH = 4;
`ifdef COLLISION_MATRIX_EVT_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    // Main instance
    logic          sof = 1'b0;
    logic [NA-1:0] reqA = '0;
    logic [NB-1:0] reqB = '0;
    logic [NA-1:0] hitPulseA, hitFrameA;
    logic [NB-1:0] hitPulseB, hitFrameB;
    logic [7:0]    pairCount;
    logic          overflow;
    collision_matrix_if #(.N_A(NA), .N_B(NB)) evt_if ();

    collision_matrix #(.N_A(NA), .N_B(NB), .EVT_DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .reqA(reqA), .reqB(reqB),
        .hitPulseA(hitPulseA), .hitPulseB(hitPulseB), .hitFrameA(hitFrameA),
        .hitFrameB(hitFrameB), .pairCount(pairCount), .overflow(overflow),
        .evt(evt_if.master));

    // Wide instance for saturation
    logic        sof2 = 1'b0;
    logic [15:0] reqA2 = '0, reqB2 = '0;
    logic [15:0] hitPulseA2, hitPulseB2, hitFrameA2, hitFrameB2;
    logic [7:0]  pairCount2;
    logic        overflow2;
    collision_matrix_if #(.N_A(16), .N_B(16)) evt2_if ();
    assign evt2_if.evtReady = 1'b1;

    collision_matrix #(.N_A(16), .N_B(16), .EVT_DEPTH(4), .CNT_W(8)) dut2 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof2), .reqA(reqA2), .reqB(reqB2),
        .hitPulseA(hitPulseA2), .hitPulseB(hitPulseB2), .hitFrameA(hitFrameA2),
        .hitFrameB(hitFrameB2), .pairCount(pairCount2), .overflow(overflow2),
        .evt(evt2_if.master));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    typedef struct { int a; int b; } ev_t;
    logic [NA-1:0] m_fa, m_pa;
    logic [NB-1:0] m_fb, m_pb;
    bit            m_seen [NA][NB];
    int            m_cnt;
    bit            m_ovf;
    ev_t           m_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fa = '0; m_fb = '0; m_pa = '0; m_pb = '0;
        foreach (m_seen[i, j]) m_seen[i][j] = 1'b0;
        m_cnt = 0; m_ovf = 1'b0;
        m_q.delete();
    endtask

    // One clock of the frame rules applied to the inputs seen at the edge.
    task automatic model_clock(input logic [NA-1:0] a, input logic [NB-1:0] b,
                               input logic s, input logic rdy);
        bit  coll, found, popped;
        int  newp;
        ev_t first;
        if (s) begin
            m_fa = '0; m_fb = '0; m_cnt = 0;
            foreach (m_seen[i, j]) m_seen[i][j] = 1'b0;
        end
        coll = (a != 0) && (b != 0);
        m_pa = '0; m_pb = '0;
        for (int i = 0; i < NA; i++)
            if (coll && a[i] && !m_fa[i]) begin m_pa[i] = 1'b1; m_fa[i] = 1'b1; end
        for (int j = 0; j < NB; j++)
            if (coll && b[j] && !m_fb[j]) begin m_pb[j] = 1'b1; m_fb[j] = 1'b1; end
        newp = 0; found = 1'b0; first = '{0, 0};
        for (int i = 0; i < NA; i++)
            for (int j = 0; j < NB; j++)
                if (a[i] && b[j] && !m_seen[i][j]) begin
                    m_seen[i][j] = 1'b1;
                    newp++;
                    if (!found) begin found = 1'b1; first = '{i, j}; end
                end
        m_cnt  = (m_cnt + newp > 255) ? 255 : m_cnt + newp;
        popped = (m_q.size() > 0) && rdy;
        if (popped) void'(m_q.pop_front());
        if (found && FIFO_EN) begin
            if (m_q.size() < DEPTH) m_q.push_back(first);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".hitPulseA"}, 32'(hitPulseA), 32'(m_pa));
        check({tag, ".hitPulseB"}, 32'(hitPulseB), 32'(m_pb));
        check({tag, ".hitFrameA"}, 32'(hitFrameA), 32'(m_fa));
        check({tag, ".hitFrameB"}, 32'(hitFrameB), 32'(m_fb));
        check({tag, ".pairCount"}, 32'(pairCount), 32'(m_cnt));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".evtValid"},  32'(evt_if.evtValid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check({tag, ".evtA"}, 32'(evt_if.evtA), 32'(m_q[0].a));
            check({tag, ".evtB"}, 32'(evt_if.evtB), 32'(m_q[0].b));
        end
    endtask

    // Drive at the falling edge, advance one rising edge, check at the next falling edge.
    task automatic step(input string tag, input logic [NA-1:0] a, input logic [NB-1:0] b,
                        input logic s, input logic rdy);
        reqA = a; reqB = b; sof = s; evt_if.evtReady = rdy;
        @(posedge clk);
        model_clock(a, b, s, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
    task automatic async_reset_check(input string tag);
        reqA = '0; reqB = '0; sof = 1'b0; evt_if.evtReady = 1'b0;
        #2 resetN = 1'b0;
        #1;
        check({tag, ".evtValid"},   32'(evt_if.evtValid), 32'd0);
        check({tag, ".overflow"},   32'(overflow), 32'd0);
        check({tag, ".pairCount"},  32'(pairCount), 32'd0);
        check({tag, ".hitPulseA"},  32'(hitPulseA), 32'd0);
        check({tag, ".hitFrameB"},  32'(hitFrameB), 32'd0);
        check({tag, ".pairCount2"}, 32'(pairCount2), 32'd0);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic step2(input logic [15:0] a, input logic [15:0] b, input logic s);
        reqA2 = a; reqB2 = b; sof2 = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        evt_if.evtReady = 1'b0;
        model_reset();
        async_reset_check("reset");

        // Single pair held for three cycles: one pulse, one count, one event (0,2)
        step("sof0", 4'b0000, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step("single", 4'b0001, 8'b0000_0100, 1'b0, 1'b0);
        step("drain1", 4'b0000, 8'h00, 1'b0, 1'b1);

        // Multi-pair cycle: four pairs, only (1,0) queued
        step("sof1", 4'b0000, 8'h00, 1'b1, 1'b0);
        step("multi", 4'b0110, 8'b0001_0001, 1'b0, 1'b0);
        step("drain2", 4'b0000, 8'h00, 1'b0, 1'b1);

        // Five pairs into a four-deep FIFO, then drain in push order
        step("sof2", 4'b0000, 8'h00, 1'b1, 1'b0);
        step("fill0", 4'b0001, 8'b0000_0001, 1'b0, 1'b0);
        step("fill1", 4'b0001, 8'b0000_0010, 1'b0, 1'b0);
        step("fill2", 4'b0010, 8'b0000_0100, 1'b0, 1'b0);
        step("fill3", 4'b0100, 8'b0000_1000, 1'b0, 1'b0);
        step("fill4", 4'b1000, 8'b0001_0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step("drain3", 4'b0000, 8'h00, 1'b0, 1'b1);

        // Frame start coinciding with a repeat of last frame's pair (2,5)
        step("sof3", 4'b0100, 8'b0010_0000, 1'b1, 1'b1);
        step("gap", 4'b0000, 8'h00, 1'b0, 1'b1);
        step("sofhit", 4'b0100, 8'b0010_0000, 1'b1, 1'b0);
        step("drain4", 4'b0000, 8'h00, 1'b0, 1'b1);

        // Saturation on the 16x16 instance: 240, +15 = 255, +1 stays 255, frame start -> 0
        step2(16'hFFFF, 16'h7FFF, 1'b1);
        check("sat.count240", 32'(pairCount2), 32'd240);
        check("sat.frameA",   32'(hitFrameA2), 32'hFFFF);
        check("sat.frameB",   32'(hitFrameB2), 32'h7FFF);
        step2(16'h7FFF, 16'h8000, 1'b0);
        check("sat.count255", 32'(pairCount2), 32'd255);
        check("sat.pulseB",   32'(hitPulseB2), 32'h8000);
        step2(16'h8000, 16'h8000, 1'b0);
        check("sat.hold255",  32'(pairCount2), 32'd255);
        check("sat.pulseA",   32'(hitPulseA2), 32'h0000);
        step2(16'h0000, 16'h0000, 1'b1);
        check("sat.clear",    32'(pairCount2), 32'd0);
        check("sat.frameClr", 32'(hitFrameA2), 32'h0000);

        // Randomized frames against the model
        for (int k = 0; k < 300; k++) begin
            step("rand", 4'($urandom_range(0, 15)), 8'($urandom & $urandom),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end

        // Reset with three queued events (overflow still latched from before)
        step("sof4", 4'b0000, 8'h00, 1'b1, 1'b0);
        step("q0", 4'b0001, 8'b0000_0001, 1'b0, 1'b0);
        step("q1", 4'b0010, 8'b0000_0001, 1'b0, 1'b0);
        step("q2", 4'b0100, 8'b0000_0001, 1'b0, 1'b0);
        async_reset_check("midreset");
        step("postreset", 4'b0000, 8'h00, 1'b0, 1'b1);
        step("postsof", 4'b1001, 8'b1000_0001, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
